ydm_wait_stage: RTL and testbench

//  Multi-cycle data-memory access stage between yEX and yWB; replaces the zero-wait yDM path.

---
 rtl/ydm_wait_stage.sv | 137 +++++++++++++
 tb/tb_ydm_wait_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ydm_wait_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ydm_wait_stage
//  Purpose  : Multi-cycle data-memory access stage between yEX and yWB.
//             Runs a req/ack handshake to a slow data memory, stalls the
//             core through in_ready and reports misaligned, conflicting and
//             timed-out accesses as a faulting completion.
//  Revision : 1.0 - initial release
// ============================================================================
module ydm_wait_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              INT,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] z,
  input  logic [DATA_W-1:0] rd2,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              out_valid,
  output logic [DATA_W-1:0] memOut,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Wait counter wide enough to hold TIMEOUT-1; cleared on every accept so it
  // never needs to wrap.
  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mem_out_q, mem_out_d;

  logic                w_any_op;
  logic                w_bad_op;

  // A request is illegal when it asks for both read and write, or when a
  // memory op targets a non-word-aligned byte address.
  always_comb begin
    w_any_op = MemRead | MemWrite;
    w_bad_op = (MemRead & MemWrite) | ((z[1:0] != 2'b00) & w_any_op);
  end

  // Next-state and datapath update: hold everything unless the FSM says so.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_out_d = mem_out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (w_bad_op) begin
            state_d = S_FAULT;
          end else if (!w_any_op) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            addr_d  = {z[DATA_W-1:2], 2'b00};
            wdata_d = rd2;
            we_d    = MemWrite;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        // An ack on the same edge as the timeout still completes normally.
        if (mem_ack) begin
          state_d = S_DONE;
          if (!we_q) begin
            mem_out_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts an access in flight.
  always_ff @(posedge clk) begin
    if (INT) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_out_q <= mem_out_d;
    end
  end

  // Handshake and completion strobes decode straight from the state register.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    mem_req   = (state_q == S_REQ);
    out_valid = (state_q == S_DONE) | (state_q == S_FAULT);
    fault     = (state_q == S_FAULT);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    memOut    = mem_out_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ydm_wait_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ydm_wait_stage
//  Purpose  : Scoreboard bench for ydm_wait_stage with a randomized memory
//             responder and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ydm_wait_stage;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              INT;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] z;
  logic [DATA_W-1:0] rd2;
  logic              MemRead;
  logic              MemWrite;
  logic              out_valid;
  logic [DATA_W-1:0] memOut;
  logic              fault;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  ydm_wait_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .INT(INT), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .rd2(rd2), .MemRead(MemRead), .MemWrite(MemWrite),
    .out_valid(out_valid), .memOut(memOut), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              flt;
    logic [DATA_W-1:0] mout;
    int                edge_n;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              we;
    int                d;
    int                hi;
  } resp_t;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    resp_busy = 0;
  logic [DATA_W-1:0] model_mem = '0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Issue one access and record what the stage and the memory should see.
  // d = number of REQ cycles the responder waits before acking.
  task automatic issue(input logic rd, input logic wr, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input int d,
                       input logic [DATA_W-1:0] rdat);
    int    budget = 0;
    int    acc;
    bit    bad, mem, ack;
    exp_t  e;
    resp_t r;
    @(negedge clk);
    while (!in_ready) begin
      // Busy cycles: offer junk that the stage has to ignore.
      in_valid = ($urandom_range(0, 1) == 1);
      z = $urandom; rd2 = $urandom;
      MemRead = $urandom_range(0, 1); MemWrite = $urandom_range(0, 1);
      budget++;
      if (budget > 200) begin
        checks++; failures++;
        $display("FAIL in_ready_wait: stage never returned to idle");
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b1; z = a; rd2 = wd; MemRead = rd; MemWrite = wr;
    acc = cyc + 1;
    bad = (rd && wr) || ((a[1:0] != 2'b00) && (rd || wr));
    mem = !bad && (rd || wr);
    if (!mem) begin
      e.flt = bad; e.mout = model_mem; e.edge_n = acc;
    end else begin
      ack = (d < TIMEOUT);
      if (ack && !wr) model_mem = rdat;
      e.flt = !ack; e.mout = model_mem;
      e.edge_n = acc + (ack ? d + 1 : TIMEOUT);
      r.addr = {a[DATA_W-1:2], 2'b00}; r.wdata = wd; r.rdata = rdat;
      r.we = wr; r.d = d; r.hi = ack ? d + 1 : TIMEOUT;
      resp_q.push_back(r);
    end
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; z = $urandom; rd2 = $urandom;
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0) || resp_busy || (resp_q.size() != 0)) begin
      @(negedge clk);
      budget++;
      if (budget > 200) begin
        checks++; failures++;
        $display("FAIL drain: %0d results and %0d accesses outstanding",
                 exp_q.size(), resp_q.size());
        exp_q.delete(); resp_q.delete();
        return;
      end
    end
  endtask

  // Monitor: every completion pulse is matched against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_valid: at cycle %0d fault=%0b", cyc, fault);
        end else begin
          e = exp_q.pop_front();
          chk("out_fault", {31'd0, fault}, {31'd0, e.flt});
          chk("out_memOut", memOut, e.mout);
          chk("out_cycle", cyc, e.edge_n);
          chk("out_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
      end
    end
  end

  // Memory responder: checks request fields and acks after the chosen delay.
  initial begin
    resp_t r;
    int    k  = 0;
    int    hi = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resp_busy && mem_req) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_mem_req: at cycle %0d", cyc);
          r.addr = mem_addr; r.wdata = mem_wdata; r.rdata = '0;
          r.we = mem_we; r.d = 1000; r.hi = -1;
        end else begin
          r = resp_q.pop_front();
        end
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, r.we});
        if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
        resp_busy = 1'b1; k = 0; hi = 0;
      end
      if (resp_busy) begin
        if (mem_req) begin
          if (mem_addr !== r.addr) chk("mem_addr_stable", mem_addr, r.addr);
          hi++;
          mem_ack   = (k == r.d);
          mem_rdata = (k == r.d) ? r.rdata : $urandom;
          k++;
        end else begin
          chk("mem_req_cycles", hi, r.hi);
          resp_busy = 1'b0;
          mem_ack   = 1'b0;
        end
      end else begin
        // Stray acks outside a request must not disturb the stage.
        mem_ack   = ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  initial begin
    int d, op, a;
    INT = 1'b1; in_valid = 1'b0; z = '0; rd2 = '0; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_memOut", memOut, 32'd0);
    INT = 1'b0;

    // Directed cases from the intended behaviour.
    issue(1'b1, 1'b0, 32'h28, 32'h0, 2, 32'h1234);
    issue(1'b0, 1'b1, 32'h2C, 32'hDEADBEEF, 0, 32'h0);
    issue(1'b1, 1'b0, 32'h29, 32'h0, 0, 32'h0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 1000, 32'h0);
    issue(1'b1, 1'b0, 32'h44, 32'h0, TIMEOUT - 1, 32'hCAFE);
    issue(1'b0, 1'b1, 32'h48, 32'h11, TIMEOUT, 32'h0);
    issue(1'b0, 1'b0, 32'h13, 32'h5, 0, 32'h0);
    issue(1'b1, 1'b1, 32'h20, 32'h7, 0, 32'h0);
    issue(1'b0, 1'b1, 32'h22, 32'h7, 0, 32'h0);

    // Randomized mix of ops, alignments and ack delays around the timeout.
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d  = ($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                        : $urandom_range(0, 5);
      case (op)
        0:       issue(1'b0, 1'b0, a, $urandom, d, $urandom);
        1:       issue(1'b1, 1'b1, a, $urandom, d, $urandom);
        2, 3, 4, 5: issue(1'b1, 1'b0, a, $urandom, d, $urandom);
        default: issue(1'b0, 1'b1, a, $urandom, d, $urandom);
      endcase
    end
    drain();

    // Reset during REQ, with the ack landing on the reset edge.
    begin
      resp_t r;
      @(negedge clk);
      in_valid = 1'b1; z = 32'h80; rd2 = 32'h0; MemRead = 1'b1; MemWrite = 1'b0;
      r.addr = 32'h80; r.wdata = '0; r.rdata = 32'hBADF00D; r.we = 1'b0;
      r.d = 3; r.hi = 4;
      resp_q.push_back(r);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      INT = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("midrst_mem_addr", mem_addr, 32'd0);
      chk("midrst_memOut", memOut, 32'd0);
      INT = 1'b0;
      model_mem = '0;
    end
    issue(1'b0, 1'b0, 32'h4, 32'h0, 0, 32'h0);
    issue(1'b1, 1'b0, 32'h84, 32'h0, 1, 32'h5A5A5A5A);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
